// File: rtl/wb_bus_arbiter_pkg.sv
// Shared Wishbone arbiter types and constants.
// Reused by the bus arbiter and the frame-memory port scheduler.
package wb_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int WB_TIMEOUT_DEFAULT = 256;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_rr_priority_pick.sv
// Round-robin pick: first requester at or above ptr, wrapping modulo N.
// Purely combinational; valid is low when nothing is requesting.
module rr_priority_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int k;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!valid && req[k]) begin
                valid  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave bus between masters,
// with a stalled-slave watchdog that errors the master and flushes.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_BYTES     = 1,
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
    input  logic [NUM_MASTERS*DATA_BYTES-1:0]    m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]             m_cti_i,
    output logic [DATA_WIDTH-1:0]                m_dat_o,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic [NUM_MASTERS-1:0]               m_busy_o,
    output logic [NUM_MASTERS-1:0]               grant_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic                                 s_we_o,
    output logic [ADDRESS_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]                s_dat_o,
    output logic [DATA_BYTES-1:0]                s_sel_o,
    output logic [2:0]                           s_cti_o,
    input  logic [DATA_WIDTH-1:0]                s_dat_i,
    input  logic                                 s_ack_i
);

    localparam int N  = NUM_MASTERS;
    localparam int IW = idx_width(N);
    localparam int WW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_t    state;
    logic [N-1:0]  grant;
    logic [IW-1:0] gidx;
    logic [IW-1:0] rr_ptr;
    logic [WW-1:0] wdog;
    logic [N-1:0]  err_q;

    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic [IW-1:0] ptr_nxt;

    logic g_cyc;
    logic g_stb;
    logic in_grant;
    logic stall;
    logic wd_hit;

    rr_priority_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (m_cyc_i),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign g_cyc    = m_cyc_i[gidx];
    assign g_stb    = m_stb_i[gidx];
    assign in_grant = (state == ST_GRANT);
    assign stall    = in_grant && g_cyc && g_stb && !s_ack_i;
    assign ptr_nxt  = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;

    // Expiry is judged on the count this stalled cycle would reach,
    // so the error lands on the cycle after the last allowed stall.
    assign wd_hit = (TIMEOUT_CYCLES > 0) &&
                    ((int'(wdog) + 1) >= TIMEOUT_CYCLES);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            grant  <= '0;
            gidx   <= '0;
            rr_ptr <= '0;
            wdog   <= '0;
            err_q  <= '0;
        end else begin
            err_q <= '0;
            unique case (state)
                ST_IDLE: begin
                    wdog <= '0;
                    if (pick_vld) begin
                        grant  <= pick_gnt;
                        gidx   <= pick_idx;
                        rr_ptr <= ptr_nxt;
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!g_cyc) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        wdog  <= '0;
                    end else if (stall) begin
                        if (wd_hit) begin
                            state <= ST_FLUSH;
                            err_q <= grant;
                            wdog  <= '0;
                        end else if (wdog != '1) begin
                            wdog <= wdog + 1'b1;
                        end
                    end else begin
                        wdog <= '0;
                    end
                end
                ST_FLUSH: begin
                    wdog <= '0;
                    if (!g_cyc) begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        m_ack_o = '0;
        if (in_grant) begin
            s_cyc_o = g_cyc;
            s_stb_o = g_cyc & g_stb;
            s_we_o  = m_we_i[gidx];
            s_adr_o = m_adr_i[gidx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            s_dat_o = m_dat_i[gidx*DATA_WIDTH +: DATA_WIDTH];
            s_sel_o = m_sel_i[gidx*DATA_BYTES +: DATA_BYTES];
            s_cti_o = m_cti_i[gidx*3 +: 3];
            m_ack_o = grant & {N{s_ack_i}};
        end
    end

    assign m_dat_o  = s_dat_i;
    assign m_err_o  = err_q;
    assign grant_o  = grant;
    assign m_busy_o = (state != ST_IDLE) ? ~grant : '0;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: two masters, 16-cycle watchdog.
module tb_wb_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int SB = 1;
    localparam int TO = 16;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    m_cyc_i;
    logic [N-1:0]    m_stb_i;
    logic [N-1:0]    m_we_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*SB-1:0] m_sel_i;
    logic [N*3-1:0]  m_cti_i;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o;
    logic [N-1:0]    m_err_o;
    logic [N-1:0]    m_busy_o;
    logic [N-1:0]    grant_o;
    logic            s_cyc_o;
    logic            s_stb_o;
    logic            s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SB-1:0]   s_sel_o;
    logic [2:0]      s_cti_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i;

    int n_vec = 0;
    int n_err = 0;

    wb_bus_arbiter #(
        .NUM_MASTERS    (N),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .DATA_BYTES     (SB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_we_i   (m_we_i),
        .m_adr_i  (m_adr_i),
        .m_dat_i  (m_dat_i),
        .m_sel_i  (m_sel_i),
        .m_cti_i  (m_cti_i),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_busy_o (m_busy_o),
        .grant_o  (grant_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_cti_o  (s_cti_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '0;
        m_cti_i = '0;
        s_dat_i = 8'h3C;
        s_ack_i = 1'b0;

        tick;
        tick;
        settle;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_scyc", 32'(s_cyc_o), 32'h0);
        chk("rst_busy", 32'(m_busy_o), 32'h0);
        chk("rst_ack", 32'(m_ack_o), 32'h0);
        chk("rst_dat", 32'(m_dat_o), 32'h3C);
        rst_i = 1'b0;
        tick;

        // single master write
        m_cyc_i       = 2'b01;
        m_stb_i       = 2'b01;
        m_we_i        = 2'b01;
        m_adr_i[15:0] = 16'h1234;
        m_dat_i[7:0]  = 8'hA5;
        m_sel_i       = 2'b01;
        m_cti_i[2:0]  = 3'b000;
        settle;
        chk("arb_latency", 32'(grant_o), 32'h0);
        chk("arb_latency_scyc", 32'(s_cyc_o), 32'h0);
        tick;
        settle;
        chk("sm_grant", 32'(grant_o), 32'h1);
        chk("sm_scyc", 32'(s_cyc_o), 32'h1);
        chk("sm_sstb", 32'(s_stb_o), 32'h1);
        chk("sm_swe", 32'(s_we_o), 32'h1);
        chk("sm_adr", 32'(s_adr_o), 32'h1234);
        chk("sm_dat", 32'(s_dat_o), 32'hA5);
        chk("sm_sel", 32'(s_sel_o), 32'h1);
        chk("sm_busy", 32'(m_busy_o), 32'h2);
        chk("sm_noack", 32'(m_ack_o), 32'h0);
        tick;
        tick;
        s_ack_i = 1'b1;
        settle;
        chk("sm_ack", 32'(m_ack_o), 32'h1);
        tick;
        s_ack_i = 1'b0;
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        settle;
        chk("sm_release_scyc", 32'(s_cyc_o), 32'h0);
        tick;
        settle;
        chk("sm_idle_grant", 32'(grant_o), 32'h0);
        chk("sm_idle_busy", 32'(m_busy_o), 32'h0);

        // reset asserted mid-grant
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        tick;
        settle;
        chk("mr_scyc_pre", 32'(s_cyc_o), 32'h1);
        s_ack_i = 1'b1;
        rst_i   = 1'b1;
        #1;
        chk("mr_scyc", 32'(s_cyc_o), 32'h0);
        chk("mr_sstb", 32'(s_stb_o), 32'h0);
        chk("mr_grant", 32'(grant_o), 32'h0);
        chk("mr_ack", 32'(m_ack_o), 32'h0);
        chk("mr_err", 32'(m_err_o), 32'h0);
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        s_ack_i = 1'b0;
        tick;
        rst_i = 1'b0;
        tick;

        // contention: m0 first, dead cycle, then m1
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        m_we_i  = 2'b00;
        m_adr_i = {16'h0200, 16'h0100};
        tick;
        settle;
        chk("c1_grant_m0", 32'(grant_o), 32'h1);
        chk("c1_adr_m0", 32'(s_adr_o), 32'h0100);
        chk("c1_busy_m0", 32'(m_busy_o), 32'h2);
        for (int i = 0; i < 3; i++) begin
            s_ack_i = 1'b1;
            settle;
            chk("c1_ack_m0", 32'(m_ack_o), 32'h1);
            tick;
        end
        s_ack_i = 1'b0;
        m_cyc_i = 2'b10;
        m_stb_i = 2'b10;
        settle;
        chk("c1_m0_drop", 32'(s_cyc_o), 32'h0);
        tick;
        settle;
        chk("c1_dead", 32'(grant_o), 32'h0);
        tick;
        settle;
        chk("c1_grant_m1", 32'(grant_o), 32'h2);
        chk("c1_adr_m1", 32'(s_adr_o), 32'h0200);
        chk("c1_busy_m1", 32'(m_busy_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            s_ack_i = 1'b1;
            settle;
            chk("c1_ack_m1", 32'(m_ack_o), 32'h2);
            tick;
        end
        s_ack_i = 1'b0;
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        tick;

        // abort: m0 drops cyc with stb high, m1 pending
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        tick;
        settle;
        chk("ab_grant_m0", 32'(grant_o), 32'h1);
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        settle;
        chk("ab_busy_m1", 32'(m_busy_o), 32'h2);
        tick;
        m_cyc_i = 2'b10;
        settle;
        chk("ab_scyc", 32'(s_cyc_o), 32'h0);
        tick;
        settle;
        chk("ab_dead", 32'(grant_o), 32'h0);
        tick;
        settle;
        chk("ab_grant_m1", 32'(grant_o), 32'h2);
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        tick;

        // watchdog on m1: slave never acks
        m_cyc_i = 2'b10;
        m_stb_i = 2'b10;
        tick;
        repeat (15) tick;
        settle;
        chk("wd_c16_err", 32'(m_err_o), 32'h0);
        chk("wd_c16_scyc", 32'(s_cyc_o), 32'h1);
        tick;
        settle;
        chk("wd_err", 32'(m_err_o), 32'h2);
        chk("wd_scyc", 32'(s_cyc_o), 32'h0);
        chk("wd_sstb", 32'(s_stb_o), 32'h0);
        chk("wd_grant", 32'(grant_o), 32'h2);
        tick;
        settle;
        chk("wd_err_pulse", 32'(m_err_o), 32'h0);
        chk("wd_flush_scyc", 32'(s_cyc_o), 32'h0);
        chk("wd_flush_busy", 32'(m_busy_o), 32'h1);
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        tick;
        settle;
        chk("wd_idle_grant", 32'(grant_o), 32'h0);
        chk("wd_idle_busy", 32'(m_busy_o), 32'h0);

        // ack exactly on the 16th stalled cycle beats the watchdog
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        tick;
        repeat (15) tick;
        s_ack_i = 1'b1;
        settle;
        chk("race_ack", 32'(m_ack_o), 32'h1);
        chk("race_err16", 32'(m_err_o), 32'h0);
        tick;
        s_ack_i = 1'b0;
        settle;
        chk("race_err17", 32'(m_err_o), 32'h0);
        chk("race_scyc", 32'(s_cyc_o), 32'h1);
        chk("race_grant", 32'(grant_o), 32'h1);
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        tick;

        // contention again: pointer now favours m1
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        tick;
        settle;
        chk("c2_grant_m1", 32'(grant_o), 32'h2);
        chk("c2_adr_m1", 32'(s_adr_o), 32'h0200);
        s_ack_i = 1'b1;
        settle;
        chk("c2_ack_m1", 32'(m_ack_o), 32'h2);
        tick;
        s_ack_i = 1'b0;
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        tick;
        settle;
        chk("c2_dead", 32'(grant_o), 32'h0);
        tick;
        settle;
        chk("c2_grant_m0", 32'(grant_o), 32'h1);
        chk("c2_adr_m0", 32'(s_adr_o), 32'h0100);
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        tick;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
